multi_operand_sum_fifos: RTL and testbench

Buffered N-operand adder: each of `n_inputs` streams is queued in its own FIFO, and the heads are joined and summed once every queue holds data. The sum, with an overflow flag, is queued in an output FIFO. It generalises the two-operand FIFO adder to N channels, selectable wrap/saturate arithmetic, overflow reporting and a result counter. The block sits between independent valid/ready producers and a single valid/ready consumer.

---
 rtl/multi_operand_sum_fifos_if.sv | 25 ++
 rtl/multi_operand_sum_fifos.sv | 120 ++++++++++++
 tb/tb_multi_operand_sum_fifos.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_operand_sum_fifos_if.sv
// Handshake bundle for the buffered N-operand adder: per-channel operand streams in,
// one result stream out, plus the running result counter.
interface multi_operand_sum_fifos_if #(
    parameter int width    = 8,
    parameter int n_inputs = 3
);
    logic [n_inputs-1:0]       in_valid;
    logic [n_inputs-1:0]       in_ready;
    logic [n_inputs*width-1:0] in_data;
    logic                      sum_valid;
    logic                      sum_ready;
    logic [width-1:0]          sum_data;
    logic                      sum_overflow;
    logic [15:0]               sum_count;

    modport master (
        output in_valid, in_data, sum_ready,
        input  in_ready, sum_valid, sum_data, sum_overflow, sum_count
    );

    modport slave (
        input  in_valid, in_data, sum_ready,
        output in_ready, sum_valid, sum_data, sum_overflow, sum_count
    );
endinterface

// File: rtl/multi_operand_sum_fifos.sv
// Buffered N-operand adder: one FIFO per operand channel, heads joined and summed when all
// hold data, result plus overflow flag queued in an output FIFO.
module multi_operand_sum_fifos #(
    parameter int width    = 8,
    parameter int depth    = 10,
    parameter int n_inputs = 3,
    parameter int saturate = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_operand_sum_fifos_if.slave bus
);
    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = $clog2(depth + 1);
    localparam int sum_w = width + $clog2(n_inputs) + 1;
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

    logic [width-1:0]    in_mem       [n_inputs][depth];
    logic [ptr_w-1:0]    in_head      [n_inputs];
    logic [ptr_w-1:0]    in_tail      [n_inputs];
    logic [cnt_w-1:0]    in_cnt       [n_inputs];
    logic [width-1:0]    in_head_data [n_inputs];
    logic [n_inputs-1:0] in_push;
    logic [n_inputs-1:0] in_nonempty;
    logic [n_inputs-1:0] in_full;

    logic [width:0]      out_mem [depth];
    logic [ptr_w-1:0]    out_head;
    logic [ptr_w-1:0]    out_tail;
    logic [cnt_w-1:0]    out_cnt;
    logic                out_nonempty;
    logic                out_full;
    logic                out_pop;
    logic                join_fire;

    logic [sum_w-1:0]    sum_wide;
    logic                overflow;
    logic [width-1:0]    result;
    logic [15:0]         sum_count_q;

    // Non-power-of-two depths need an explicit wrap rather than natural rollover.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == last_ptr) ? '0 : p + ptr_w'(1);
    endfunction

    always_comb begin
        in_push      = '0;
        in_nonempty  = '0;
        in_full      = '0;
        in_head_data = '{default: '0};
        for (int i = 0; i < n_inputs; i++) begin
            in_nonempty[i]  = (in_cnt[i] != '0);
            in_full[i]      = (in_cnt[i] == full_cnt);
            in_push[i]      = bus.in_valid[i] & ~in_full[i];
            in_head_data[i] = in_mem[i][in_head[i]];
        end
    end

    assign out_nonempty = (out_cnt != '0);
    assign out_full     = (out_cnt == full_cnt);
    assign out_pop      = out_nonempty & bus.sum_ready;
    assign join_fire    = (&in_nonempty) & ~out_full;

    // Internal sum is wide enough that it can never wrap, so any bit above width means overflow.
    always_comb begin
        sum_wide = '0;
        for (int i = 0; i < n_inputs; i++) begin
            sum_wide = sum_wide + sum_w'(in_head_data[i]);
        end
        overflow = |sum_wide[sum_w-1:width];
        result   = ((saturate != 0) && overflow) ? '1 : sum_wide[width-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < n_inputs; i++) begin
                in_head[i] <= '0;
                in_tail[i] <= '0;
                in_cnt[i]  <= '0;
            end
            out_head    <= '0;
            out_tail    <= '0;
            out_cnt     <= '0;
            sum_count_q <= '0;
        end else begin
            for (int i = 0; i < n_inputs; i++) begin
                if (in_push[i]) in_tail[i] <= next_ptr(in_tail[i]);
                if (join_fire)  in_head[i] <= next_ptr(in_head[i]);
                case ({in_push[i], join_fire})
                    2'b10:   in_cnt[i] <= in_cnt[i] + cnt_w'(1);
                    2'b01:   in_cnt[i] <= in_cnt[i] - cnt_w'(1);
                    default: in_cnt[i] <= in_cnt[i];
                endcase
            end
            if (join_fire) out_tail <= next_ptr(out_tail);
            if (out_pop)   out_head <= next_ptr(out_head);
            case ({join_fire, out_pop})
                2'b10:   out_cnt <= out_cnt + cnt_w'(1);
                2'b01:   out_cnt <= out_cnt - cnt_w'(1);
                default: out_cnt <= out_cnt;
            endcase
            if (join_fire) sum_count_q <= sum_count_q + 16'd1;
        end
    end

    // Storage is not reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < n_inputs; i++) begin
            if (in_push[i]) in_mem[i][in_tail[i]] <= bus.in_data[i*width +: width];
        end
        if (join_fire) out_mem[out_tail] <= {overflow, result};
    end

    assign bus.in_ready     = ~in_full;
    assign bus.sum_valid    = out_nonempty;
    assign bus.sum_data     = out_nonempty ? out_mem[out_head][width-1:0] : '0;
    assign bus.sum_overflow = out_nonempty & out_mem[out_head][width];
    assign bus.sum_count    = sum_count_q;
endmodule

// File: tb/tb_multi_operand_sum_fifos.sv
// Scoreboard bench for multi_operand_sum_fifos: a wrap-mode and a saturate-mode instance
// share identical stimulus; expected sums are formed from accepted operands.
module tb_multi_operand_sum_fifos;
    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 3;

    typedef struct {
        logic [W-1:0] wrap_val;
        logic [W-1:0] sat_val;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_operand_sum_fifos_if #(.width(W), .n_inputs(N)) bus_w ();
    multi_operand_sum_fifos_if #(.width(W), .n_inputs(N)) bus_s ();

    assign bus_s.in_valid  = bus_w.in_valid;
    assign bus_s.in_data   = bus_w.in_data;
    assign bus_s.sum_ready = bus_w.sum_ready;

    multi_operand_sum_fifos #(.width(W), .depth(D), .n_inputs(N), .saturate(0)) u_dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    multi_operand_sum_fifos #(.width(W), .depth(D), .n_inputs(N), .saturate(1)) u_dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_formed = 0;
    int pops     = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc  = 0;
    int cyc      = 0;
    logic [W-1:0] ch_q [N][$];
    exp_t exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic [W-1:0] d2);
        bus_w.in_valid = v;
        bus_w.in_data  = {d2, d1, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < N; i++) ch_q[i].delete();
        n_formed = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted operands, form expected results in order, compare at each pop.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus_w.in_valid[i] && bus_w.in_ready[i]) ch_q[i].push_back(bus_w.in_data[i*W +: W]);
            end
            while (ch_q[0].size() > 0 && ch_q[1].size() > 0 && ch_q[2].size() > 0) begin
                int total;
                exp_t e;
                total = int'(ch_q[0].pop_front()) + int'(ch_q[1].pop_front()) + int'(ch_q[2].pop_front());
                e.wrap_val = W'(total % 256);
                e.ovf      = (total > 255);
                e.sat_val  = e.ovf ? 8'd255 : W'(total % 256);
                exp_q.push_back(e);
                n_formed++;
            end
            if (bus_w.sum_valid && bus_w.sum_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wrap_data", bus_w.sum_data, e.wrap_val);
                    chk("wrap_ovf", bus_w.sum_overflow, e.ovf);
                    chk("sat_valid", bus_s.sum_valid, 1);
                    chk("sat_data", bus_s.sum_data, e.sat_val);
                    chk("sat_ovf", bus_s.sum_overflow, e.ovf);
                end
                pops++;
                if (pops == 1) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
        end
    end

    initial begin
        int base_pops;
        bus_w.in_valid  = '0;
        bus_w.in_data   = '0;
        bus_w.sum_ready = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus_w.in_ready, 3'b111);
        chk("rst_sum_valid", bus_w.sum_valid, 0);
        chk("rst_sum_data", bus_w.sum_data, 0);
        chk("rst_sum_ovf", bus_w.sum_overflow, 0);
        chk("rst_sum_count", bus_w.sum_count, 0);
        rst = 1'b1;
        step();

        // Basic: all three operands in one cycle, result two edges later.
        drive(3'b111, 8'd10, 8'd20, 8'd30);
        step();
        drive(3'b000, 8'd0, 8'd0, 8'd0);
        chk("basic_lat_early", bus_w.sum_valid, 0);
        step();
        chk("basic_lat_valid", bus_w.sum_valid, 1);
        chk("basic_data", bus_w.sum_data, 60);
        chk("basic_ovf", bus_w.sum_overflow, 0);
        chk("basic_count", bus_w.sum_count, 1);
        step();
        chk("basic_drained", bus_w.sum_valid, 0);

        // Skewed arrival: ch0 at cycles 0..2, ch1 at 5..7, ch2 at 9..11.
        for (int c = 0; c < 15; c++) begin
            logic [N-1:0] v;
            v[0] = (c <= 2);
            v[1] = (c >= 5 && c <= 7);
            v[2] = (c >= 9 && c <= 11);
            drive(v, W'(c + 1), W'(10 * (c - 4)), 8'd100);
            step();
            chk($sformatf("skew_valid_c%0d", c), bus_w.sum_valid, (c >= 10 && c <= 12) ? 1 : 0);
        end
        drive(3'b000, 8'd0, 8'd0, 8'd0);
        chk("skew_count", bus_w.sum_count, 32'(n_formed));
        chk("skew_sb_empty", exp_q.size(), 0);

        // Overflow in both arithmetic modes, then the all-ones boundary without overflow.
        drive(3'b111, 8'd200, 8'd100, 8'd50);
        step();
        drive(3'b111, 8'd255, 8'd0, 8'd0);
        step();
        drive(3'b000, 8'd0, 8'd0, 8'd0);
        chk("ovf_head_data", bus_w.sum_data, 94);
        chk("ovf_head_flag", bus_w.sum_overflow, 1);
        chk("ovf_head_sat", bus_s.sum_data, 255);
        repeat (4) step();
        chk("ovf_sb_empty", exp_q.size(), 0);

        // Backpressure: everything fills, then 8 results drain in order.
        bus_w.sum_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(3'b111, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            step();
        end
        drive(3'b000, 8'd0, 8'd0, 8'd0);
        chk("bp_in_ready", bus_w.in_ready, 3'b000);
        chk("bp_sum_valid", bus_w.sum_valid, 1);
        chk("bp_count", bus_w.sum_count, 32'(n_formed - 4));
        base_pops = pops;
        bus_w.sum_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!bus_w.sum_valid) break;
        end
        chk("bp_drain_done", bus_w.sum_valid, 0);
        chk("bp_pops", pops - base_pops, 8);
        chk("bp_sb_empty", exp_q.size(), 0);
        chk("bp_in_ready_after", bus_w.in_ready, 3'b111);

        // Reset with three results queued.
        bus_w.sum_ready = 1'b0;
        drive(3'b111, 8'd5, 8'd6, 8'd7);
        step();
        drive(3'b111, 8'd8, 8'd9, 8'd10);
        step();
        drive(3'b111, 8'd11, 8'd12, 8'd13);
        step();
        drive(3'b000, 8'd0, 8'd0, 8'd0);
        repeat (2) step();
        chk("pre_rst_valid", bus_w.sum_valid, 1);
        rst = 1'b0;
        #1;
        clear_model();
        chk("mid_rst_valid", bus_w.sum_valid, 0);
        chk("mid_rst_data", bus_w.sum_data, 0);
        chk("mid_rst_ovf", bus_w.sum_overflow, 0);
        chk("mid_rst_in_ready", bus_w.in_ready, 3'b111);
        chk("mid_rst_count", bus_w.sum_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_w.sum_ready = 1'b1;
        step();
        base_pops = pops;
        drive(3'b111, 8'd1, 8'd2, 8'd3);
        step();
        drive(3'b000, 8'd0, 8'd0, 8'd0);
        step();
        chk("post_rst_data", bus_w.sum_data, 6);
        repeat (2) step();
        chk("post_rst_pops", pops - base_pops, 1);
        chk("post_rst_count", bus_w.sum_count, 1);
        chk("post_rst_sb_empty", exp_q.size(), 0);

        // Full-rate streaming after a fresh reset: wraps every pointer many times.
        rst = 1'b0;
        #1;
        clear_model();
        step();
        rst = 1'b1;
        step();
        pops = 0;
        for (int c = 0; c < 50; c++) begin
            drive(3'b111, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            step();
        end
        drive(3'b000, 8'd0, 8'd0, 8'd0);
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && !bus_w.sum_valid) break;
            step();
        end
        chk("tp_drain_done", bus_w.sum_valid, 0);
        chk("tp_pops", pops, 50);
        chk("tp_back_to_back", last_pop_cyc - first_pop_cyc, 49);
        chk("tp_count", bus_w.sum_count, 50);
        chk("tp_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
